// File: rtl/dma_burst_engine_if.sv
// Bus-side port bundle of the DMA burst engine: arbiter request/grant,
// burst handshake, write/read beat strobes and bus error.
interface dma_burst_engine_if;
  logic [31:0] address_dataIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic        errorIN;
  logic        granted;

  logic [31:0] address_dataOUT;
  logic [3:0]  byte_enableOUT;
  logic [7:0]  burst_sizeOUT;
  logic        read_n_writeOUT;
  logic        begin_transactionOUT;
  logic        end_transactionOUT;
  logic        data_validOUT;
  logic        busyOUT;
  logic        request;

  modport master (
    input  address_dataIN, end_transactionIN, data_validIN, busyIN, errorIN, granted,
    output address_dataOUT, byte_enableOUT, burst_sizeOUT, read_n_writeOUT,
           begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT, request
  );

  modport slave (
    output address_dataIN, end_transactionIN, data_validIN, busyIN, errorIN, granted,
    input  address_dataOUT, byte_enableOUT, burst_sizeOUT, read_n_writeOUT,
           begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT, request
  );
endinterface

// File: rtl/dma_burst_engine.sv
// Bus-master DMA: moves a block of 32-bit words between the local buffer and
// the shared bus, split into bursts of at most MAX_BURST beats, with
// re-arbitration before every burst.
//
//  state | meaning
//  IDLE  | waiting for start_write / start_read
//  REQ   | requesting the bus, waiting for grant
//  HS    | one-cycle burst handshake (address, size, direction)
//  PREF  | write only: first buffer word is being fetched
//  WDATA | write beats, one per cycle unless the slave stalls
//  RDATA | read beats from the slave into the buffer
//  WEND  | write burst end strobe
//  GAP   | one idle cycle between bursts with request dropped
module dma_burst_engine #(
  parameter int BUF_AW    = 9,
  parameter int MAX_BURST = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_write,
  input  logic              start_read,
  input  logic [31:0]       cmd_bus_address,
  input  logic [BUF_AW-1:0] cmd_buffer_start,
  input  logic [BUF_AW-1:0] cmd_word_count,
  input  logic [3:0]        cmd_byte_enable,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              dma_error,
  output logic [BUF_AW-1:0] bufferAddress,
  output logic [31:0]       dataIn,
  output logic              writeEnable,
  input  logic [31:0]       dataOut,
  dma_burst_engine_if.master bus
);

  // Wide enough for remaining+1 (up to 2**BUF_AW) and for MAX_BURST (up to 256).
  localparam int LW = (BUF_AW + 1 > 9) ? BUF_AW + 1 : 9;

  typedef enum logic [2:0] {IDLE, REQ, HS, PREF, WDATA, RDATA, WEND, GAP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [BUF_AW-1:0] ptr_q, ptr_d;
  logic [BUF_AW-1:0] rem_q, rem_d;
  logic              rnw_q, rnw_d;
  logic [3:0]        be_q, be_d;
  logic [LW-1:0]     beat_q, beat_d;
  logic [31:0]       data_q, data_d;
  logic              error_q, error_d;
  logic              busy_q, done_q, request_q, begin_q, dvalid_q, wend_q;

  logic [LW-1:0]     rem_plus1, blen, r_count;
  logic              last_burst, w_accept, r_beat, abort, burst_end;

  assign rem_plus1  = {{(LW-BUF_AW){1'b0}}, rem_q} + LW'(1);
  assign blen       = (rem_plus1 > LW'(MAX_BURST)) ? LW'(MAX_BURST) : rem_plus1;
  assign last_burst = (rem_plus1 == blen);
  assign abort      = (state_q != IDLE) && bus.errorIN;
  assign w_accept   = (state_q == WDATA) && !bus.busyIN && !bus.errorIN;
  assign r_beat     = (state_q == RDATA) && bus.data_validIN && !bus.errorIN;
  assign r_count    = beat_q + {{(LW-1){1'b0}}, r_beat};
  assign burst_end  = !abort && ((state_q == WEND) ||
                      ((state_q == RDATA) && bus.end_transactionIN && (r_count == blen)));

  // Next-state and datapath update for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    rnw_d   = rnw_q;
    be_d    = be_q;
    beat_d  = beat_q;
    data_d  = data_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (start_write || start_read) begin
          state_d = REQ;
          addr_d  = cmd_bus_address;
          ptr_d   = cmd_buffer_start;
          rem_d   = cmd_word_count;
          rnw_d   = !start_write;
          be_d    = cmd_byte_enable;
          beat_d  = '0;
          error_d = 1'b0;
        end
      end
      REQ: begin
        beat_d = '0;
        if (bus.granted) state_d = HS;
      end
      HS:   state_d = rnw_q ? RDATA : PREF;
      PREF: begin
        data_d  = dataOut;
        state_d = WDATA;
      end
      WDATA: begin
        if (w_accept) begin
          data_d = dataOut;
          ptr_d  = ptr_q + BUF_AW'(1);
          beat_d = beat_q + LW'(1);
          if (beat_q == blen - LW'(1)) state_d = WEND;
        end
      end
      RDATA: begin
        if (r_beat) begin
          ptr_d  = ptr_q + BUF_AW'(1);
          beat_d = beat_q + LW'(1);
        end
        if (bus.end_transactionIN && (r_count != blen)) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      WEND:    state_d = state_q;
      GAP:     state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (burst_end) begin
      addr_d  = addr_q + (32'(blen) << 2);
      rem_d   = rem_q - BUF_AW'(blen);
      state_d = last_burst ? IDLE : GAP;
    end
    if (abort) begin
      state_d = IDLE;
      error_d = 1'b1;
    end
  end

  // State, datapath registers and state-decoded outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      ptr_q     <= '0;
      rem_q     <= '0;
      rnw_q     <= 1'b0;
      be_q      <= '0;
      beat_q    <= '0;
      data_q    <= '0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      request_q <= 1'b0;
      begin_q   <= 1'b0;
      dvalid_q  <= 1'b0;
      wend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      rnw_q     <= rnw_d;
      be_q      <= be_d;
      beat_q    <= beat_d;
      data_q    <= data_d;
      error_q   <= error_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_q != IDLE) && (state_d == IDLE);
      request_q <= (state_d != IDLE) && (state_d != GAP);
      begin_q   <= (state_d == HS);
      dvalid_q  <= (state_d == WDATA);
      wend_q    <= (state_d == WEND);
    end
  end

  // Buffer address: HS addresses the first word so it lands in data_q at the
  // end of PREF; from PREF on the address runs one word ahead, two on accept.
  always_comb begin
    bufferAddress = ptr_q;
    if (state_q == PREF)       bufferAddress = ptr_q + BUF_AW'(1);
    else if (state_q == WDATA) bufferAddress = ptr_q + (w_accept ? BUF_AW'(2) : BUF_AW'(1));
  end

  assign writeEnable = r_beat;
  assign dataIn      = r_beat ? bus.address_dataIN : 32'h0;

  assign dma_busy  = busy_q;
  assign dma_done  = done_q;
  assign dma_error = error_q;

  assign bus.address_dataOUT      = (state_q == HS)    ? addr_q :
                                    (state_q == WDATA) ? data_q : 32'h0;
  assign bus.byte_enableOUT       = (state_q == HS) ? be_q : 4'h0;
  assign bus.burst_sizeOUT        = (state_q == HS) ? 8'(blen - LW'(1)) : 8'h0;
  assign bus.read_n_writeOUT      = (state_q == HS) && rnw_q;
  assign bus.begin_transactionOUT = begin_q;
  assign bus.data_validOUT        = dvalid_q;
  assign bus.end_transactionOUT   = wend_q ||
                                    (bus.errorIN && ((state_q == WDATA) || (state_q == RDATA)));
  assign bus.busyOUT              = 1'b0;
  assign bus.request              = request_q;

endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed bench for dma_burst_engine: write bursts, burst splitting, slave
// stalls, read with buffer wrap, read abort and start arbitration.
module tb_dma_burst_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_write, start_read;
  logic [31:0] cmd_bus_address;
  logic [8:0]  cmd_buffer_start, cmd_word_count;
  logic [3:0]  cmd_byte_enable;
  logic        dma_busy, dma_done, dma_error;
  logic [8:0]  bufferAddress;
  logic [31:0] dataIn;
  logic        writeEnable;
  logic [31:0] dataOut;
  logic        grant_en;
  logic        mon_clr;

  dma_burst_engine_if bus_if();
  assign bus_if.granted = bus_if.request & grant_en;

  dma_burst_engine #(.BUF_AW(9), .MAX_BURST(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .start_write      (start_write),
    .start_read       (start_read),
    .cmd_bus_address  (cmd_bus_address),
    .cmd_buffer_start (cmd_buffer_start),
    .cmd_word_count   (cmd_word_count),
    .cmd_byte_enable  (cmd_byte_enable),
    .dma_busy         (dma_busy),
    .dma_done         (dma_done),
    .dma_error        (dma_error),
    .bufferAddress    (bufferAddress),
    .dataIn           (dataIn),
    .writeEnable      (writeEnable),
    .dataOut          (dataOut),
    .bus              (bus_if.master)
  );

  always #5 clock = ~clock;

  // Buffer read port: registered read, data one cycle after the address.
  logic [31:0] mem [512];
  always @(posedge clock) dataOut <= mem[bufferAddress];

  function automatic logic [31:0] mem_val(input int i);
    return (i < 5) ? 32'hA0 + 32'(i) : 32'hB000_0000 + 32'(i);
  endfunction

  // Monitor: records handshakes, beats, buffer writes and strobes.
  logic [31:0] hs_addr [8];
  logic [7:0]  hs_size [8];
  logic        hs_rnw  [8];
  logic [31:0] wbeat   [64];
  int          wb_cyc  [64];
  logic [31:0] stall_data [8];
  logic [8:0]  we_addr [16];
  logic [31:0] we_data [16];
  int hs_n, wb_n, stall_n, we_n, end_n, done_n, gap_n, cyc;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      hs_n <= 0; wb_n <= 0; stall_n <= 0; we_n <= 0;
      end_n <= 0; done_n <= 0; gap_n <= 0;
    end else begin
      if (bus_if.begin_transactionOUT && hs_n < 8) begin
        hs_addr[hs_n] <= bus_if.address_dataOUT;
        hs_size[hs_n] <= bus_if.burst_sizeOUT;
        hs_rnw[hs_n]  <= bus_if.read_n_writeOUT;
        hs_n <= hs_n + 1;
      end
      if (bus_if.data_validOUT && !bus_if.busyIN && wb_n < 64) begin
        wbeat[wb_n]  <= bus_if.address_dataOUT;
        wb_cyc[wb_n] <= cyc;
        wb_n <= wb_n + 1;
      end
      if (bus_if.data_validOUT && bus_if.busyIN && stall_n < 8) begin
        stall_data[stall_n] <= bus_if.address_dataOUT;
        stall_n <= stall_n + 1;
      end
      if (writeEnable && we_n < 16) begin
        we_addr[we_n] <= bufferAddress;
        we_data[we_n] <= dataIn;
        we_n <= we_n + 1;
      end
      if (bus_if.end_transactionOUT) end_n <= end_n + 1;
      if (dma_done) done_n <= done_n + 1;
      if (dma_busy && !bus_if.request) gap_n <= gap_n + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step(1);
    mon_clr = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [8:0] bs, input logic [8:0] wc);
    cmd_bus_address  = a;
    cmd_buffer_start = bs;
    cmd_word_count   = wc;
    cmd_byte_enable  = 4'hF;
    start_write      = wr;
    start_read       = rd;
    step(1);
    start_write      = 1'b0;
    start_read       = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (dma_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_val(tag, 32'(seen), 32'd1);
    step(1);
  endtask

  // Read slave: waits for the handshake, sends nb beats back to back; at
  // index err_beat it raises errorIN with that beat and stops.
  task automatic read_slave(input int nb, input logic [31:0] base, input int err_beat);
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (bus_if.begin_transactionOUT) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("rd_handshake_seen", 32'(seen), 32'd1);
    for (int i = 0; i < nb; i++) begin
      @(posedge clock);
      #1;
      bus_if.data_validIN   = 1'b1;
      bus_if.address_dataIN = base + 32'(i);
      bus_if.errorIN        = (i == err_beat);
      if (i == err_beat) break;
    end
    @(posedge clock);
    #1;
    bus_if.data_validIN   = 1'b0;
    bus_if.errorIN        = 1'b0;
    bus_if.address_dataIN = 32'h0;
    if (err_beat >= nb) begin
      bus_if.end_transactionIN = 1'b1;
      step(1);
      bus_if.end_transactionIN = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    start_write = 1'b0; start_read = 1'b0;
    cmd_bus_address = '0; cmd_buffer_start = '0; cmd_word_count = '0; cmd_byte_enable = '0;
    bus_if.address_dataIN = '0; bus_if.end_transactionIN = 1'b0; bus_if.data_validIN = 1'b0;
    bus_if.busyIN = 1'b0; bus_if.errorIN = 1'b0;
    grant_en = 1'b1;
    mon_clr  = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = mem_val(i);

    repeat (3) @(negedge clock);
    check_val("rst_busy",    32'(dma_busy), 32'd0);
    check_val("rst_done",    32'(dma_done), 32'd0);
    check_val("rst_error",   32'(dma_error), 32'd0);
    check_val("rst_request", 32'(bus_if.request), 32'd0);
    check_val("rst_begin",   32'(bus_if.begin_transactionOUT), 32'd0);
    check_val("rst_addr_out", bus_if.address_dataOUT, 32'd0);
    check_val("rst_buf_addr", 32'(bufferAddress), 32'd0);
    check_val("rst_we",      32'(writeEnable), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(2);

    // Write 5 words from buffer[0..4]: one burst, consecutive beats.
    clear_mon();
    issue(1'b1, 1'b0, 32'h1000_0000, 9'd0, 9'd4);
    wait_done("w5_done_timeout");
    step(2);
    check_val("w5_hs_count", 32'(hs_n), 32'd1);
    check_val("w5_hs_addr", hs_addr[0], 32'h1000_0000);
    check_val("w5_hs_size", 32'(hs_size[0]), 32'd4);
    check_val("w5_hs_rnw", 32'(hs_rnw[0]), 32'd0);
    check_val("w5_beats", 32'(wb_n), 32'd5);
    for (int i = 0; i < 5; i++) check_val($sformatf("w5_beat%0d", i), wbeat[i], 32'hA0 + 32'(i));
    check_val("w5_consecutive", 32'(wb_cyc[4] - wb_cyc[0]), 32'd4);
    check_val("w5_end_pulses", 32'(end_n), 32'd1);
    check_val("w5_done_pulses", 32'(done_n), 32'd1);
    check_val("w5_error", 32'(dma_error), 32'd0);
    check_val("w5_gap", 32'(gap_n), 32'd0);

    // Write 20 words at 0x40000100: bursts of 16 then 4, request gap between.
    clear_mon();
    issue(1'b1, 1'b0, 32'h4000_0100, 9'd8, 9'd19);
    wait_done("w20_done_timeout");
    step(2);
    check_val("w20_hs_count", 32'(hs_n), 32'd2);
    check_val("w20_hs0_addr", hs_addr[0], 32'h4000_0100);
    check_val("w20_hs0_size", 32'(hs_size[0]), 32'd15);
    check_val("w20_hs1_addr", hs_addr[1], 32'h4000_0140);
    check_val("w20_hs1_size", 32'(hs_size[1]), 32'd3);
    check_val("w20_beats", 32'(wb_n), 32'd20);
    for (int i = 0; i < 20; i++) check_val($sformatf("w20_beat%0d", i), wbeat[i], 32'hB000_0008 + 32'(i));
    check_val("w20_gap_cycles", 32'(gap_n), 32'd1);
    check_val("w20_end_pulses", 32'(end_n), 32'd2);
    check_val("w20_done_pulses", 32'(done_n), 32'd1);

    // Write 3 words, slave stalls beat 1 for two cycles.
    clear_mon();
    issue(1'b1, 1'b0, 32'h2000_0000, 9'd100, 9'd2);
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus_if.data_validOUT) break;
    end
    @(posedge clock);
    #1;
    bus_if.busyIN = 1'b1;
    step(2);
    bus_if.busyIN = 1'b0;
    wait_done("wstall_done_timeout");
    step(2);
    check_val("wstall_beats", 32'(wb_n), 32'd3);
    check_val("wstall_beat0", wbeat[0], 32'hB000_0064);
    check_val("wstall_beat1", wbeat[1], 32'hB000_0065);
    check_val("wstall_beat2", wbeat[2], 32'hB000_0066);
    check_val("wstall_cycles", 32'(stall_n), 32'd2);
    check_val("wstall_hold0", stall_data[0], 32'hB000_0065);
    check_val("wstall_hold1", stall_data[1], 32'hB000_0065);
    check_val("wstall_end_pulses", 32'(end_n), 32'd1);

    // Read 4 words into buffer 510: buffer pointer wraps to 0.
    clear_mon();
    issue(1'b0, 1'b1, 32'h3000_0000, 9'd510, 9'd3);
    read_slave(4, 32'hC0, 99);
    wait_done("r4_done_timeout");
    step(2);
    check_val("r4_hs_rnw", 32'(hs_rnw[0]), 32'd1);
    check_val("r4_hs_size", 32'(hs_size[0]), 32'd3);
    check_val("r4_hs_addr", hs_addr[0], 32'h3000_0000);
    check_val("r4_writes", 32'(we_n), 32'd4);
    check_val("r4_waddr0", 32'(we_addr[0]), 32'd510);
    check_val("r4_waddr1", 32'(we_addr[1]), 32'd511);
    check_val("r4_waddr2", 32'(we_addr[2]), 32'd0);
    check_val("r4_waddr3", 32'(we_addr[3]), 32'd1);
    for (int i = 0; i < 4; i++) check_val($sformatf("r4_wdata%0d", i), we_data[i], 32'hC0 + 32'(i));
    check_val("r4_done_pulses", 32'(done_n), 32'd1);
    check_val("r4_error", 32'(dma_error), 32'd0);

    // 8-word read, errorIN with beat 2: abort.
    clear_mon();
    issue(1'b0, 1'b1, 32'h5000_0000, 9'd20, 9'd7);
    read_slave(8, 32'hD0, 2);
    check_val("rerr_busy_next", 32'(dma_busy), 32'd0);
    check_val("rerr_done_next", 32'(dma_done), 32'd1);
    check_val("rerr_error_set", 32'(dma_error), 32'd1);
    step(3);
    check_val("rerr_writes", 32'(we_n), 32'd2);
    check_val("rerr_waddr0", 32'(we_addr[0]), 32'd20);
    check_val("rerr_waddr1", 32'(we_addr[1]), 32'd21);
    check_val("rerr_wdata1", we_data[1], 32'hD1);
    check_val("rerr_end_pulses", 32'(end_n), 32'd1);
    check_val("rerr_done_pulses", 32'(done_n), 32'd1);
    check_val("rerr_error_sticky", 32'(dma_error), 32'd1);

    // Simultaneous starts: write wins; a read start mid-transfer is ignored.
    clear_mon();
    issue(1'b1, 1'b1, 32'h6000_0000, 9'd0, 9'd9);
    step(4);
    issue(1'b0, 1'b1, 32'h7000_0000, 9'd300, 9'd0);
    wait_done("both_done_timeout");
    step(4);
    check_val("both_hs_count", 32'(hs_n), 32'd1);
    check_val("both_hs_rnw", 32'(hs_rnw[0]), 32'd0);
    check_val("both_hs_size", 32'(hs_size[0]), 32'd9);
    check_val("both_beats", 32'(wb_n), 32'd10);
    check_val("both_beat9", wbeat[9], 32'hB000_0009);
    check_val("both_no_bufwrite", 32'(we_n), 32'd0);
    check_val("both_done_pulses", 32'(done_n), 32'd1);
    check_val("both_error_cleared", 32'(dma_error), 32'd0);
    check_val("both_idle", 32'(dma_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
